// File: rtl/jt12_kon_sched.sv
// jt12_kon_sched: queues reg 0x28 key-on writes and releases one per slot frame,
// holding each command until the sequencer has passed op S4 of its channel.
module jt12_kon_sched #(
   parameter int DEPTH  = 4,
   parameter int num_ch = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clk_en,
   input  logic                     wr,
   input  logic [7:0]               din,
   input  logic [1:0]               next_op,
   input  logic [2:0]               next_ch,
   output logic [3:0]               keyon_op,
   output logic [2:0]               keyon_ch,
   output logic                     up_keyon,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   output logic                     err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t        state;
   logic [6:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [4:0]    timer;
   logic [2:0]    wr_ch;
   logic          ch_ok, full, match, push, pop, unused_din;
   assign unused_din = din[3];
   // with three channels ch[2] is ignored, so codes 4-6 alias 0-2
   assign wr_ch = num_ch == 3 ? {1'b0, din[1:0]} : din[2:0];
   assign ch_ok = din[1:0] != 2'd3;
   assign full  = level == (AW+1)'(DEPTH);
   assign match = next_ch == keyon_ch && next_op == 2'd3;
   assign pop   = clk_en && state == WAIT && (match || timer == 5'd23);
   assign push  = wr && ch_ok && (!full || pop);
   assign busy  = state != IDLE || level != '0;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
         if (wr && ch_ok && !push) ovf <= 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {din[7:4], wr_ch};
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         keyon_op <= '0;
         keyon_ch <= '0;
         up_keyon <= 1'b0;
         timer    <= '0;
         err      <= 1'b0;
      end else if (clk_en) begin
         if (state == IDLE && level != '0) begin
            state    <= ISSUE;
            keyon_op <= mem[rd_ptr][6:3];
            keyon_ch <= mem[rd_ptr][2:0];
            up_keyon <= 1'b1;
         end else if (state == ISSUE) begin
            state    <= WAIT;
            up_keyon <= 1'b0;
            timer    <= '0;
         end else if (state == WAIT) begin
            timer <= timer + 5'd1;
            if (pop) begin
               state <= IDLE;
               err   <= err | !match;
            end
         end
      end
   end
endmodule

// File: tb/tb_jt12_kon_sched.sv
// tb_jt12_kon_sched: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference of the key-on scheduler.
module tb_jt12_kon_sched;
   localparam int DEPTH = 4;
   logic clk = 0, rst_n = 0, clk_en = 0, wr = 0;
   logic [7:0] din = 0;
   logic [1:0] next_op = 0;
   logic [2:0] next_ch = 0;
   logic [3:0] keyon_op, k3_op;
   logic [2:0] keyon_ch, k3_ch, level, lvl3;
   logic up_keyon, busy, ovf, err, up3, busy3, ovf3, err3;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   jt12_kon_sched #(.DEPTH(DEPTH), .num_ch(6)) dut (.clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .wr(wr), .din(din), .next_op(next_op), .next_ch(next_ch), .keyon_op(keyon_op),
      .keyon_ch(keyon_ch), .up_keyon(up_keyon), .busy(busy), .level(level), .ovf(ovf), .err(err));
   jt12_kon_sched #(.DEPTH(DEPTH), .num_ch(3)) dut3 (.clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .wr(wr), .din(din), .next_op(next_op), .next_ch(next_ch), .keyon_op(k3_op),
      .keyon_ch(k3_ch), .up_keyon(up3), .busy(busy3), .level(lvl3), .ovf(ovf3), .err(err3));
   // reference: pending commands in a queue, in-flight command aged in clk_en edges since its pulse
   logic [6:0] q[$];
   bit infl, m_up, m_ovf, m_err;
   int age;
   logic [3:0] m_op;
   logic [2:0] m_ch;
   bit seq_on = 0, prev_up = 0;
   int slot = 0;
   int pch[$];
   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction
   function automatic void model_step();
      bit popped = 0;
      bit hit = next_ch == m_ch && next_op == 2'd3;
      if (!rst_n) begin
         q.delete();
         infl = 0; m_op = 0; m_ch = 0; m_up = 0; m_ovf = 0; m_err = 0;
         return;
      end
      if (clk_en) begin
         m_up = 0;
         if (infl) begin
            age++;
            if (age >= 2 && (hit || age == 25)) begin
               popped = 1;
               infl = 0;
               if (!hit) m_err = 1;
            end
         end else if (q.size() != 0) begin
            {m_op, m_ch} = q[0];
            m_up = 1; infl = 1; age = 0;
         end
      end
      if (wr && din[1:0] != 2'd3) begin
         if (q.size() < DEPTH || popped) q.push_back({din[7:4], din[2:0]});
         else m_ovf = 1;
      end
      if (popped) void'(q.pop_front());
   endfunction
   task automatic tick(input logic w, input logic [7:0] d, input logic ce);
      int idx;
      @(negedge clk);
      wr = w; din = d; clk_en = ce;
      if (seq_on) begin
         idx = slot % 6;
         next_op = 2'(slot / 6);
         next_ch = 3'(idx < 3 ? idx : idx + 1);
      end
      model_step();
      @(posedge clk);
      #1;
      if (seq_on && ce) slot = (slot + 1) % 24;
      chk("keyon_op", keyon_op, m_op);
      chk("keyon_ch", keyon_ch, m_ch);
      chk("up_keyon", up_keyon, m_up);
      chk("busy", busy, int'(infl || q.size() != 0));
      chk("level", level, q.size());
      chk("ovf", ovf, m_ovf);
      chk("err", err, m_err);
      if (up_keyon && !prev_up) pch.push_back(keyon_ch);
      prev_up = up_keyon;
   endtask
   task automatic do_reset();
      rst_n = 0;
      tick(0, 8'h00, 0);
      rst_n = 1;
      pch.delete();
   endtask
   typedef struct {logic w; logic [7:0] d; int lvl; int ov;} vec_t;
   vec_t tv[8];
   bit busy_prev;
   initial begin
      tv[0] = '{1, 8'hF3, 0, 0};
      tv[1] = '{1, 8'hF7, 0, 0};
      tv[2] = '{1, 8'hF1, 1, 0};
      tv[3] = '{1, 8'h02, 2, 0};
      tv[4] = '{1, 8'hF4, 3, 0};
      tv[5] = '{1, 8'h25, 4, 0};
      tv[6] = '{1, 8'hF6, 4, 1};
      tv[7] = '{0, 8'h00, 4, 1};
      do_reset();
      tick(0, 8'h00, 1);
      chk("rst_level", level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf_err", {ovf, err, up_keyon}, 0);
      // write table with clk_en low: invalid channels, fill, overflow
      foreach (tv[i]) begin
         tick(tv[i].w, tv[i].d, 0);
         chk("tbl_level", level, tv[i].lvl);
         chk("tbl_ovf", ovf, tv[i].ov);
      end
      seq_on = 1;
      repeat (140) tick(0, 8'h00, 1);
      chk("ovf_pulses", pch.size(), 4);
      if (pch.size() == 4) begin
         chk("ovf_ord0", pch[0], 1); chk("ovf_ord1", pch[1], 2);
         chk("ovf_ord2", pch[2], 4); chk("ovf_ord3", pch[3], 5);
      end
      chk("ovf_idle", busy, 0);
      // single write with sequencer running
      do_reset();
      tick(1, 8'hF1, 1);
      busy_prev = 1;
      repeat (40) begin
         tick(0, 8'h00, 1);
         if (busy_prev && !busy) chk("pop_slot", {next_op, next_ch}, {2'd3, 3'd1});
         busy_prev = busy;
      end
      chk("single_pulses", pch.size(), 1);
      chk("single_op", keyon_op, 4'hF);
      chk("single_ch", keyon_ch, 1);
      chk("single_busy", busy, 0);
      // burst of four on consecutive clocks
      do_reset();
      tick(1, 8'h10, 1); tick(1, 8'h21, 1); tick(1, 8'h42, 1); tick(1, 8'h84, 1);
      chk("burst_level", level, 4);
      chk("burst_ovf", ovf, 0);
      repeat (130) tick(0, 8'h00, 1);
      chk("burst_pulses", pch.size(), 4);
      if (pch.size() == 4) begin
         chk("burst_ord0", pch[0], 0); chk("burst_ord1", pch[1], 1);
         chk("burst_ord2", pch[2], 2); chk("burst_ord3", pch[3], 4);
      end
      // timeout, then a match on the 24th WAIT cycle
      for (int pass = 0; pass < 2; pass++) begin
         seq_on = 0; next_op = 0; next_ch = 1;
         do_reset();
         tick(1, 8'hF1, 0);
         for (int k = 1; k <= 26; k++) begin
            if (k == 26 && pass == 1) next_op = 3;
            tick(0, 8'h00, 1);
            if (k == 25) chk("to_pre_err", {busy, err}, 2'b10);
         end
         chk("to_err", err, pass == 0 ? 1 : 0);
         chk("to_level", level, 0);
         chk("to_busy", busy, 0);
      end
      // reset while waiting with two entries queued
      do_reset();
      next_op = 0;
      tick(1, 8'hF1, 0); tick(1, 8'hF2, 0);
      repeat (3) tick(0, 8'h00, 1);
      chk("rw_busy", busy, 1);
      rst_n = 0;
      tick(0, 8'h00, 1);
      rst_n = 1;
      chk("rw_outs", {keyon_op, keyon_ch, up_keyon, ovf, err}, 0);
      chk("rw_level", level, 0);
      pch.delete();
      seq_on = 1;
      repeat (60) tick(0, 8'h00, 1);
      chk("rw_pulses", pch.size(), 0);
      // three-channel instance: ch[2] ignored, ch code 3 rejected
      do_reset();
      tick(1, 8'hF5, 0);
      chk("c3_push", lvl3, 1);
      tick(1, 8'hF3, 0); tick(1, 8'hF7, 0);
      chk("c3_invalid", lvl3, 1);
      chk("c3_ovf", ovf3, 0);
      repeat (40) tick(0, 8'h00, 1);
      chk("c3_ch", k3_ch, 1);
      chk("c3_op", k3_op, 4'hF);
      chk("c3_idle", {busy3, err3}, 0);
      // random traffic against the reference
      for (int i = 0; i < 4000; i++) begin
         if (i % 100 == 0) seq_on = $urandom_range(0, 3) != 0;
         if (!seq_on) begin
            next_op = 2'($urandom_range(0, 3));
            next_ch = 3'($urandom_range(0, 7));
         end
         rst_n = $urandom_range(0, 599) != 0;
         tick($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 9) < 7);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
